// File: rtl/sevenseg_mux_if.sv
// Producer/display bundle for the multiplexed seven-segment driver.
// The master drives value and controls; the slave drives the pin-facing outputs.
interface sevenseg_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic                      lz_en;
    logic                      blank;
    logic [NUM_DIGITS-1:0]     digit_n;
    logic [6:0]                sevenseg;
    logic [6:0]                sevenseg_n;
    logic                      dp_n;
    logic                      frame;

    modport master (
        output load, value, dp, lz_en, blank,
        input  digit_n, sevenseg, sevenseg_n, dp_n, frame
    );

    modport slave (
        input  load, value, dp, lz_en, blank,
        output digit_n, sevenseg, sevenseg_n, dp_n, frame
    );
endinterface

// File: rtl/sevenseg_mux.sv
// Time-multiplexed hex display driver: scans one digit per prescaler tick and
// swaps in newly loaded values only at frame boundaries so a frame never tears.
module sevenseg_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 50000
) (
    input logic           clk,
    input logic           rst,
    sevenseg_mux_if.slave bus
);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]         div_q, div_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]   cur_dn_q, cur_dn_d;
    logic [6:0]              cur_seg_q, cur_seg_d;
    logic                    cur_dpn_q, cur_dpn_d;
    logic [NUM_DIGITS-1:0]   out_dn_q, out_dn_d;
    logic [6:0]              out_seg_q, out_seg_d;
    logic                    out_dpn_q, out_dpn_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              sel_nib;
    logic                    sel_dp;
    logic                    sel_dark;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [NUM_DIGITS-1:0]   dn_new;
    logic [6:0]              seg_new;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign tick = (div_q == LastDiv);
    assign wrap = tick && (idx_q == LastIdx);

    always_comb begin : p_scan
        div_d = tick ? '0 : div_q + DivW'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        end
    end

    // A load landing exactly on the wrap edge bypasses pend and shows at once.
    always_comb begin : p_buffer
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (bus.load && wrap) begin
            disp_d     = bus.value;
            disp_dp_d  = bus.dp;
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pend_d     = bus.value;
            pend_dp_d  = bus.dp;
            pend_vld_d = 1'b1;
        end else if (wrap && pend_vld_q) begin
            disp_d     = pend_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
        end
    end

    // Decode the digit that will be selected after this edge, from the next display state.
    always_comb begin : p_decode
        logic upper_zero;
        upper_zero = 1'b1;
        lz_dark    = '0;
        sel_nib    = '0;
        sel_dp     = 1'b0;
        sel_dark   = 1'b0;
        dn_new     = '1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_d[4*k +: 4] == 4'h0);
            lz_dark[k] = upper_zero && (k != 0);
        end
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_d == IdxW'(k)) begin
                sel_nib   = disp_d[4*k +: 4];
                sel_dp    = disp_dp_d[k];
                sel_dark  = bus.lz_en && lz_dark[k];
                dn_new[k] = 1'b0;
            end
        end
        seg_new = sel_dark ? 7'h00 : hex_to_seg(sel_nib);
    end

    always_comb begin : p_outputs
        cur_dn_d  = cur_dn_q;
        cur_seg_d = cur_seg_q;
        cur_dpn_d = cur_dpn_q;
        if (tick) begin
            cur_dn_d  = dn_new;
            cur_seg_d = seg_new;
            cur_dpn_d = ~sel_dp;
        end
        // Blank only masks the pins; the held digit reappears on release.
        out_dn_d  = bus.blank ? '1 : cur_dn_d;
        out_seg_d = bus.blank ? 7'h00 : cur_seg_d;
        out_dpn_d = bus.blank ? 1'b1 : cur_dpn_d;
        frame_d   = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            idx_q      <= LastIdx;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            cur_dn_q   <= '1;
            cur_seg_q  <= 7'h00;
            cur_dpn_q  <= 1'b1;
            out_dn_q   <= '1;
            out_seg_q  <= 7'h00;
            out_dpn_q  <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            cur_dn_q   <= cur_dn_d;
            cur_seg_q  <= cur_seg_d;
            cur_dpn_q  <= cur_dpn_d;
            out_dn_q   <= out_dn_d;
            out_seg_q  <= out_seg_d;
            out_dpn_q  <= out_dpn_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.digit_n    = out_dn_q;
    assign bus.sevenseg   = out_seg_q;
    assign bus.sevenseg_n = ~out_seg_q;
    assign bus.dp_n       = out_dpn_q;
    assign bus.frame      = frame_q;
endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux (4 digits, 4 clocks per slot): stimulus queues
// expected pin states per clock edge; a negedge monitor pops and compares them.
module tb_sevenseg_mux;
    localparam int unsigned ND = 4;
    localparam int unsigned CD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sevenseg_mux_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [3:0] dn;
        logic [6:0] seg;
        logic       dpn;
        logic       frm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mx;
    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic push(input int e, input logic [3:0] dn, input logic [6:0] seg,
                        input logic dpn, input logic frm);
        exp_t x;
        x.at_edge = e;
        x.dn      = dn;
        x.seg     = seg;
        x.dpn     = dpn;
        x.frm     = frm;
        sb_q.push_back(x);
    endtask

    task automatic push_off(input int e, input logic frm);
        push(e, 4'hF, 7'h00, 1'b1, frm);
    endtask

    // One full frame starting at wrap edge w, no leading-zero suppression involved.
    task automatic push_frame(input int w, input logic [15:0] v, input logic [3:0] d);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] dn;
            dn    = 4'hF;
            dn[k] = 1'b0;
            push(w + 4 * k, dn, ref_seg(v[4*k +: 4]), ~d[k], k == 0);
            if (k == 0) push(w + 1, dn, ref_seg(v[3:0]), ~d[0], 1'b0);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp    = d;
        bus.load  = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].at_edge <= edge_cnt) begin
                mx = sb_q.pop_front();
                n_cmp++;
                if (mx.at_edge < edge_cnt) begin
                    n_bad++;
                    $display("FAIL missed check: edge %0d seen at %0d", mx.at_edge, edge_cnt);
                end else if (bus.digit_n !== mx.dn || bus.sevenseg !== mx.seg ||
                             bus.sevenseg_n !== ~mx.seg || bus.dp_n !== mx.dpn ||
                             bus.frame !== mx.frm) begin
                    n_bad++;
                    $display("FAIL pins @edge %0d: got dn=%b seg=%h segn=%h dpn=%b frm=%b, want dn=%b seg=%h segn=%h dpn=%b frm=%b",
                             mx.at_edge, bus.digit_n, bus.sevenseg, bus.sevenseg_n, bus.dp_n,
                             bus.frame, mx.dn, mx.seg, ~mx.seg, mx.dpn, mx.frm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int base, base2, w, w4, w5, w6, w7, w8, w9;
        bus.load  = 1'b0;
        bus.value = '0;
        bus.dp    = '0;
        bus.lz_en = 1'b0;
        bus.blank = 1'b0;
        rst       = 1'b1;

        @(posedge clk);
        #1;
        push_off(edge_cnt, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = edge_cnt;
        push_off(base + 3, 1'b0);
        push(base + 4, 4'hE, 7'h3F, 1'b1, 1'b1);

        // Reset mid-scan: pins must drop immediately.
        wait_edge(base + 9);
        rst = 1'b1;
        push_off(edge_cnt, 1'b0);
        wait_edge(base + 11);
        rst   = 1'b0;
        base2 = edge_cnt;
        w     = base2 + 4;
        push_off(base2 + 3, 1'b0);
        push_frame(w, 16'h0000, 4'h0);

        // All 16 codes, each load deferred to the following frame.
        wait_edge(w + 1);
        do_load(16'hFEDC, 4'b0101);
        push_frame(w + 16, 16'hFEDC, 4'b0101);
        wait_edge(w + 17);
        do_load(16'h3210, 4'b1010);
        push_frame(w + 32, 16'h3210, 4'b1010);
        wait_edge(w + 33);
        do_load(16'h7654, 4'b0000);
        push_frame(w + 48, 16'h7654, 4'b0000);
        wait_edge(w + 49);
        do_load(16'hBA98, 4'b0000);
        push_frame(w + 64, 16'hBA98, 4'b0000);

        // Load while digit 2 is lit, then a load on the wrap edge itself.
        w4 = w + 64;
        wait_edge(w4 + 9);
        do_load(16'h1234, 4'b0000);
        push_frame(w4 + 16, 16'h1234, 4'b0000);
        w5 = w4 + 32;
        push_frame(w5, 16'h8421, 4'b0001);
        wait_edge(w5 - 1);
        do_load(16'h8421, 4'b0001);

        // Second load within a frame overwrites the first.
        wait_edge(w5 + 2);
        do_load(16'h1111, 4'b0000);
        wait_edge(w5 + 6);
        do_load(16'h2222, 4'b0000);
        w6 = w5 + 16;
        push_frame(w6, 16'h2222, 4'b0000);

        // Leading-zero suppression.
        wait_edge(w6 + 2);
        bus.lz_en = 1'b1;
        do_load(16'h0070, 4'b0000);
        w7 = w6 + 16;
        push(w7,      4'hE, 7'h3F, 1'b1, 1'b1);
        push(w7 + 1,  4'hE, 7'h3F, 1'b1, 1'b0);
        push(w7 + 4,  4'hD, 7'h07, 1'b1, 1'b0);
        push(w7 + 8,  4'hB, 7'h00, 1'b1, 1'b0);
        push(w7 + 12, 4'h7, 7'h00, 1'b1, 1'b0);
        wait_edge(w7 + 2);
        do_load(16'h0000, 4'b1000);
        w8 = w7 + 16;
        push(w8,      4'hE, 7'h3F, 1'b1, 1'b1);
        push(w8 + 4,  4'hD, 7'h00, 1'b1, 1'b0);
        push(w8 + 8,  4'hB, 7'h00, 1'b1, 1'b0);
        push(w8 + 12, 4'h7, 7'h00, 1'b0, 1'b0);

        // Blank for 10 clocks across a frame wrap.
        wait_edge(w8 + 2);
        do_load(16'h9ABC, 4'b0000);
        w9 = w8 + 16;
        push(w9,     4'hE, 7'h39, 1'b1, 1'b1);
        push(w9 + 1, 4'hE, 7'h39, 1'b1, 1'b0);
        push(w9 + 4, 4'hD, 7'h7C, 1'b1, 1'b0);
        push(w9 + 6, 4'hD, 7'h7C, 1'b1, 1'b0);
        push_off(w9 + 7,  1'b0);
        push_off(w9 + 8,  1'b0);
        push_off(w9 + 12, 1'b0);
        push_off(w9 + 16, 1'b1);
        push(w9 + 17, 4'hE, 7'h39, 1'b1, 1'b0);
        push(w9 + 20, 4'hD, 7'h7C, 1'b1, 1'b0);
        wait_edge(w9 + 6);
        bus.blank = 1'b1;
        wait_edge(w9 + 16);
        bus.blank = 1'b0;

        wait_edge(w9 + 22);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
